// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter.
// Bytes enter through a valid/ready handshake and wait in a small FIFO.
// Each byte goes out as an async frame: start bit, LSB-first data bits, then
// stop bit(s). The line idles high and uart_txd is always driven from a flop.
module uart_tx_fifo #(
   parameter int BIT_RATE     = 9600,
   parameter int CLK_HZ       = 50_000_000,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          tx_valid,
   input  logic [7:0]                    tx_data,
   output logic                          tx_ready,
   input  logic                          uart_tx_en,
   output logic                          uart_txd,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int CPB = CLK_HZ / BIT_RATE;
   localparam int CW  = $clog2(CPB);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int BW  = 3;

   localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
   logic                    txd_q, txd_d;

   logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]           level_q, level_d;
   logic                    ready_q, busy_q;

   logic                    push_s, pop_s, can_pop_s, cnt_end_s;
   logic [PAYLOAD_BITS-1:0] head_s;
   logic                    unused_data_s;

   // Data bits above the payload width are intentionally dropped.
   assign unused_data_s = ^{1'b0, tx_data};

   // The push decision uses only the registered ready, so a pop on a full
   // FIFO never opens room in the same cycle.
   assign push_s    = tx_valid && ready_q;
   assign can_pop_s = (level_q != {LW{1'b0}}) && uart_tx_en;
   assign cnt_end_s = (cnt_q == CNT_LAST);
   assign head_s    = mem_q[rd_ptr_q];

   assign tx_ready   = ready_q;
   assign tx_busy    = busy_q;
   assign fifo_level = level_q;
   assign uart_txd   = txd_q;

   // Registers for the FSM state, bit timing counters, shifter and line flop.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= {CW{1'b0}};
         bit_q   <= {BW{1'b0}};
         shift_q <= {PAYLOAD_BITS{1'b0}};
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

   // Next-state logic. Every bit period is exactly CPB cycles long, and a
   // pop at the end of STOP starts the next frame with no idle gap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (can_pop_s) begin
               pop_s   = 1'b1;
               state_d = S_START;
               cnt_d   = {CW{1'b0}};
               bit_d   = {BW{1'b0}};
               shift_d = head_s;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (cnt_end_s) begin
               state_d = S_DATA;
               cnt_d   = {CW{1'b0}};
               bit_d   = {BW{1'b0}};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_end_s) begin
               cnt_d = {CW{1'b0}};
               if (bit_q == DATA_LAST) begin
                  state_d = S_STOP;
                  bit_d   = {BW{1'b0}};
               end else begin
                  bit_d   = bit_q + BW'(1);
                  shift_d = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_end_s) begin
               cnt_d = {CW{1'b0}};
               if (bit_q == STOP_LAST) begin
                  bit_d = {BW{1'b0}};
                  if (can_pop_s) begin
                     pop_s   = 1'b1;
                     state_d = S_START;
                     shift_d = head_s;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = {CW{1'b0}};
            bit_d   = {BW{1'b0}};
         end
      endcase
   end

   // Line value computed from the next state, so the flop switches with it.
   always_comb begin
      txd_d = 1'b1;
      case (state_d)
         S_IDLE:  txd_d = 1'b1;
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shift_d[0];
         S_STOP:  txd_d = 1'b1;
         default: txd_d = 1'b1;
      endcase
   end

   // FIFO occupancy: a simultaneous push and pop leaves the level unchanged.
   always_comb begin
      level_d = level_q;
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // FIFO pointers, level and the registered ready/busy flags.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {LW{1'b0}};
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         level_q <= level_d;
         ready_q <= (level_d != LVL_FULL);
         busy_q  <= (state_d != S_IDLE) || (level_d != {LW{1'b0}});
      end
   end

   // FIFO storage; stale contents are harmless because the pointers reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= tx_data[PAYLOAD_BITS-1:0];
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with CPB = 10.
// dut0: 8 data bits, 1 stop bit. dut1: 7 data bits, 2 stop bits.
module tb_uart_tx_fifo;

   logic       clk;
   logic       resetn;
   logic       tx_valid, tx_valid1;
   logic [7:0] tx_data, tx_data1;
   logic       tx_ready, tx_ready1;
   logic       uart_tx_en, uart_tx_en1;
   logic       uart_txd, uart_txd1;
   logic       tx_busy, tx_busy1;
   logic [4:0] fifo_level, fifo_level1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   uart_tx_fifo #(
      .BIT_RATE(100_000), .CLK_HZ(1_000_000),
      .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16)
   ) dut0 (
      .clk(clk), .resetn(resetn), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .uart_tx_en(uart_tx_en), .uart_txd(uart_txd),
      .tx_busy(tx_busy), .fifo_level(fifo_level)
   );

   uart_tx_fifo #(
      .BIT_RATE(100_000), .CLK_HZ(1_000_000),
      .PAYLOAD_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16)
   ) dut1 (
      .clk(clk), .resetn(resetn), .tx_valid(tx_valid1), .tx_data(tx_data1),
      .tx_ready(tx_ready1), .uart_tx_en(uart_tx_en1), .uart_txd(uart_txd1),
      .tx_busy(tx_busy1), .fifo_level(fifo_level1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] data;
      logic [9:0] line;  // bit k = line level in slot k (0 = start, 9 = stop)
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic goto(input int t);
      while (cyc < t) step(1);
   endtask

   task automatic push0(input logic [7:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      step(1);
      tx_valid = 1'b0;
   endtask

   // Poll for the falling edge of a start bit; s = first cycle the line is low.
   task automatic wait_start(output int s);
      bit ok;
      ok = 1'b0;
      s  = cyc;
      for (int i = 0; i < 300; i++) begin
         if (uart_txd == 1'b0) begin
            ok = 1'b1;
            s  = cyc;
            break;
         end
         step(1);
      end
      check("start_seen", 32'(ok), 32'd1);
   endtask

   // Decode one dut0 frame whose start bit begins in cycle s.
   task automatic rx_at(input int s, output logic [7:0] b);
      goto(s + 5);
      check("rx_start_bit", 32'(uart_txd), 32'd0);
      for (int i = 0; i < 8; i++) begin
         goto(s + 15 + 10 * i);
         b[i] = uart_txd;
      end
      goto(s + 95);
      check("rx_stop_bit", 32'(uart_txd), 32'd1);
   endtask

   // Push one byte into an idle dut0 and check every bit centre and the frame end.
   task automatic send_check(input logic [7:0] d, input logic [9:0] line);
      push0(d);
      check("idle_before_start", 32'(uart_txd), 32'd1);
      check("level_after_push", 32'(fifo_level), 32'd1);
      step(1);
      check("start_latency", 32'(uart_txd), 32'd0);
      check("level_after_pop", 32'(fifo_level), 32'd0);
      step(5);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("bit%0d_of_%02h", k, d), 32'(uart_txd), 32'(line[k]));
         if (k < 9) step(10);
      end
      step(4);
      check("busy_last_cycle", 32'(tx_busy), 32'd1);
      step(1);
      check("busy_after_frame", 32'(tx_busy), 32'd0);
   endtask

   initial begin
      int         p, s, lows, lines;
      logic [7:0] b0, b1, b2, b;

      vecs[0] = '{data: 8'hA5, line: 10'b1_10100101_0};
      vecs[1] = '{data: 8'h55, line: 10'b1_01010101_0};
      vecs[2] = '{data: 8'h00, line: 10'b1_00000000_0};
      vecs[3] = '{data: 8'hFF, line: 10'b1_11111111_0};
      vecs[4] = '{data: 8'h3C, line: 10'b1_00111100_0};

      resetn      = 1'b0;
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      uart_tx_en  = 1'b1;
      tx_valid1   = 1'b0;
      tx_data1    = 8'h00;
      uart_tx_en1 = 1'b1;
      step(3);
      check("rst_txd", 32'(uart_txd), 32'd1);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      resetn = 1'b1;
      step(2);
      check("idle_txd", 32'(uart_txd), 32'd1);
      check("idle_txd1", 32'(uart_txd1), 32'd1);

      // Single frames, table driven (first entry is 0xA5).
      for (int v = 0; v < 5; v++) begin
         send_check(vecs[v].data, vecs[v].line);
         step(3);
      end

      // Loopback "Hi\n", back to back, frames must be contiguous.
      tx_valid = 1'b1;
      tx_data  = 8'h48;
      step(1);
      p = cyc;
      tx_data = 8'h69;
      step(1);
      tx_data = 8'h0A;
      step(1);
      tx_valid = 1'b0;
      rx_at(p + 1, b0);
      goto(p + 100);
      check("lb_f1_stop_end", 32'(uart_txd), 32'd1);
      goto(p + 101);
      check("lb_f2_start_no_gap", 32'(uart_txd), 32'd0);
      rx_at(p + 101, b1);
      rx_at(p + 201, b2);
      goto(p + 300);
      check("lb_busy_last", 32'(tx_busy), 32'd1);
      goto(p + 301);
      check("lb_busy_end", 32'(tx_busy), 32'd0);
      check("lb_char0", 32'(b0), 32'h48);
      check("lb_char1", 32'(b1), 32'h69);
      check("lb_char2", 32'(b2), 32'h0A);
      lines = 0;
      if (b0 == 8'h0A) lines++;
      if (b1 == 8'h0A) lines++;
      if (b2 == 8'h0A) lines++;
      check("lb_lines", 32'(lines), 32'd1);

      // Fill with transmit disabled: 17 offers, 16 accepted.
      uart_tx_en = 1'b0;
      step(2);
      tx_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tx_data = 8'h10 + 8'(i);
         step(1);
         check($sformatf("full_level_%0d", i), 32'(fifo_level), (i < 16) ? 32'(i + 1) : 32'd16);
         check($sformatf("full_ready_%0d", i), 32'(tx_ready), (i + 1 < 16) ? 32'd1 : 32'd0);
      end
      tx_valid = 1'b0;
      step(5);
      check("full_no_tx", 32'(uart_txd), 32'd1);
      check("full_busy", 32'(tx_busy), 32'd1);
      uart_tx_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wait_start(s);
         rx_at(s, b);
         check($sformatf("drain_%0d", i), 32'(b), 32'(8'h10 + 8'(i)));
      end
      step(10);
      check("drain_level", 32'(fifo_level), 32'd0);
      check("drain_busy", 32'(tx_busy), 32'd0);

      // Enable dropped during data bit 3 of frame 1 with a second byte queued.
      tx_valid = 1'b1;
      tx_data  = 8'h81;
      step(1);
      p = cyc;
      tx_data = 8'h42;
      step(1);
      tx_valid = 1'b0;
      s = p + 1;
      goto(s + 45);
      check("en_bit3", 32'(uart_txd), 32'd0);
      uart_tx_en = 1'b0;
      goto(s + 85);
      check("en_bit7", 32'(uart_txd), 32'd1);
      goto(s + 95);
      check("en_stop", 32'(uart_txd), 32'd1);
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (uart_txd == 1'b0) lows++;
      end
      check("en_no_second_start", 32'(lows), 32'd0);
      check("en_level_held", 32'(fifo_level), 32'd1);
      check("en_busy", 32'(tx_busy), 32'd1);
      uart_tx_en = 1'b1;
      wait_start(s);
      rx_at(s, b);
      check("en_second_byte", 32'(b), 32'h42);
      step(10);

      // Asynchronous reset during data bit 5.
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      step(1);
      p = cyc;
      step(1);
      tx_valid = 1'b0;
      goto(p + 1 + 65);
      check("pre_reset_low", 32'(uart_txd), 32'd0);
      check("pre_reset_level", 32'(fifo_level), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("arst_txd", 32'(uart_txd), 32'd1);
      check("arst_level", 32'(fifo_level), 32'd0);
      check("arst_busy", 32'(tx_busy), 32'd0);
      check("arst_ready", 32'(tx_ready), 32'd1);
      step(2);
      resetn = 1'b1;
      step(2);
      check("post_reset_txd", 32'(uart_txd), 32'd1);
      send_check(8'h55, 10'b1_01010101_0);

      // 7 data bits, 2 stop bits: 0xFF then 0x80 (bit 7 must be ignored).
      for (int r = 0; r < 2; r++) begin
         tx_valid1 = 1'b1;
         tx_data1  = (r == 0) ? 8'hFF : 8'h80;
         step(1);
         p = cyc;
         tx_valid1 = 1'b0;
         s = p + 1;
         goto(s);
         check("p7_start_latency", 32'(uart_txd1), 32'd0);
         goto(s + 5);
         check("p7_start_bit", 32'(uart_txd1), 32'd0);
         for (int i = 0; i < 7; i++) begin
            goto(s + 15 + 10 * i);
            check($sformatf("p7_r%0d_bit%0d", r, i), 32'(uart_txd1), (r == 0) ? 32'd1 : 32'd0);
         end
         goto(s + 85);
         check("p7_stop1", 32'(uart_txd1), 32'd1);
         goto(s + 95);
         check("p7_stop2", 32'(uart_txd1), 32'd1);
         goto(s + 99);
         check("p7_busy_last", 32'(tx_busy1), 32'd1);
         goto(s + 100);
         check("p7_busy_end", 32'(tx_busy1), 32'd0);
         step(3);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
